// File: rtl/maze_player_ctrl.sv
// Player movement sequencer: probes the wall map along the leading edge of the footprint, then commits or rejects the move.
// Latency: request in cycle T -> lookups T+1..T+4, result visible T+6, idle again at T+6+MOVE_PERIOD (out-of-range: T+1+MOVE_PERIOD).
// Backpressure: button requests are only sampled in IDLE; busy is high from accept until the cooldown expires.
module maze_player_ctrl #(
  parameter int unsigned MAP_DIM     = 41,
  parameter int unsigned PCELLS      = 4,
  parameter int unsigned START_X     = 1,
  parameter int unsigned START_Y     = 1,
  parameter int unsigned GOAL_X      = 36,
  parameter int unsigned GOAL_Y      = 36,
  parameter int unsigned MOVE_PERIOD = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] state,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       map_req,
  output logic [5:0] map_row,
  output logic [5:0] map_col,
  input  logic       map_wall,
  output logic [5:0] player_x,
  output logic [5:0] player_y,
  output logic       busy,
  output logic       hit_wall,
  output logic       goal
);

  localparam int unsigned IW = $clog2(PCELLS);
  localparam int unsigned CW = $clog2(MOVE_PERIOD + 1);
  localparam logic [5:0] MAX_POS  = 6'(MAP_DIM - PCELLS);
  localparam logic [5:0] EDGE_OFS = 6'(PCELLS - 1);
  localparam logic [5:0] START_XV = 6'(START_X);
  localparam logic [5:0] START_YV = 6'(START_Y);
  localparam logic [5:0] GOAL_XV  = 6'(GOAL_X);
  localparam logic [5:0] GOAL_YV  = 6'(GOAL_Y);
  localparam logic [IW-1:0] LAST_IDX = IW'(PCELLS - 1);
  localparam logic [CW-1:0] COOL_INIT = CW'(MOVE_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, PROBE, DECIDE, COOL} fsm_t;
  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  fsm_t          fsm;
  dir_t          dir;
  logic [5:0]    tgt_x, tgt_y;
  logic [IW-1:0] idx;
  logic          wall_flag;
  logic [CW-1:0] cool_cnt;
  logic [3:0]    prev_state;

  logic       in_stage;
  logic       stage_reload;
  logic       req_any;
  dir_t       req_dir;
  logic [5:0] nxt_x, nxt_y;
  logic       req_oob;

  // Cell on the leading edge of the target footprint for lookup index i.
  function automatic logic [11:0] edge_cell(input dir_t d, input logic [5:0] tx,
                                            input logic [5:0] ty, input logic [IW-1:0] i);
    logic [5:0] r, c;
    r = ty;
    c = tx;
    case (d)
      DIR_UP:    begin r = ty;            c = tx + 6'(i);     end
      DIR_DOWN:  begin r = ty + EDGE_OFS; c = tx + 6'(i);     end
      DIR_LEFT:  begin r = ty + 6'(i);    c = tx;             end
      default:   begin r = ty + 6'(i);    c = tx + EDGE_OFS;  end
    endcase
    return {r, c};
  endfunction

  // Stage detection and direction decode; a 6-bit wrap on underflow lands above MAX_POS.
  always_comb begin
    in_stage     = (state == 4'd2) || (state == 4'd4) || (state == 4'd6);
    stage_reload = in_stage && (prev_state != state);
    req_any      = btn_up || btn_down || btn_left || btn_right;
    req_dir      = DIR_RIGHT;
    nxt_x        = player_x;
    nxt_y        = player_y;
    if (btn_up) begin
      req_dir = DIR_UP;
      nxt_y   = player_y - 6'd1;
    end else if (btn_down) begin
      req_dir = DIR_DOWN;
      nxt_y   = player_y + 6'd1;
    end else if (btn_left) begin
      req_dir = DIR_LEFT;
      nxt_x   = player_x - 6'd1;
    end else begin
      req_dir = DIR_RIGHT;
      nxt_x   = player_x + 6'd1;
    end
    req_oob = (nxt_x > MAX_POS) || (nxt_y > MAX_POS);
  end

  // Move sequencer: accept, probe leading edge, decide, cool down.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm        <= IDLE;
      dir        <= DIR_RIGHT;
      tgt_x      <= START_XV;
      tgt_y      <= START_YV;
      idx        <= '0;
      wall_flag  <= 1'b0;
      cool_cnt   <= '0;
      prev_state <= state;
      player_x   <= START_XV;
      player_y   <= START_YV;
      busy       <= 1'b0;
      hit_wall   <= 1'b0;
      goal       <= 1'b0;
      map_req    <= 1'b0;
      map_row    <= '0;
      map_col    <= '0;
    end else begin
      prev_state <= state;
      hit_wall   <= 1'b0;
      goal       <= 1'b0;
      if (!in_stage || stage_reload) begin
        fsm      <= IDLE;
        player_x <= START_XV;
        player_y <= START_YV;
        busy     <= 1'b0;
        cool_cnt <= '0;
        map_req  <= 1'b0;
        map_row  <= '0;
        map_col  <= '0;
      end else begin
        case (fsm)
          IDLE: begin
            if (req_any) begin
              dir   <= req_dir;
              tgt_x <= nxt_x;
              tgt_y <= nxt_y;
              busy  <= 1'b1;
              if (req_oob) begin
                hit_wall <= 1'b1;
                cool_cnt <= COOL_INIT;
                fsm      <= COOL;
              end else begin
                idx                <= '0;
                wall_flag          <= 1'b0;
                map_req            <= 1'b1;
                {map_row, map_col} <= edge_cell(req_dir, nxt_x, nxt_y, '0);
                fsm                <= PROBE;
              end
            end
          end
          PROBE: begin
            // The response for lookup idx-1 arrives while lookup idx is on the bus.
            if (idx != '0) begin
              wall_flag <= wall_flag | map_wall;
            end
            if (idx == LAST_IDX) begin
              map_req <= 1'b0;
              map_row <= '0;
              map_col <= '0;
              fsm     <= DECIDE;
            end else begin
              idx                <= idx + IW'(1);
              {map_row, map_col} <= edge_cell(dir, tgt_x, tgt_y, idx + IW'(1));
            end
          end
          DECIDE: begin
            if (wall_flag || map_wall) begin
              hit_wall <= 1'b1;
            end else begin
              player_x <= tgt_x;
              player_y <= tgt_y;
              goal     <= (tgt_x == GOAL_XV) && (tgt_y == GOAL_YV);
            end
            cool_cnt <= COOL_INIT;
            fsm      <= COOL;
          end
          default: begin
            if (cool_cnt == '0) begin
              busy <= 1'b0;
              fsm  <= IDLE;
            end else begin
              cool_cnt <= cool_cnt - CW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule
